// File: rtl/workers_cpu_0_cpu_mult_seq.sv
// Multi-cycle MUL/MULXUU/MULXSU/MULXSS sequencer around workers_cpu_0_cpu_mult_cell; result on valid/ready.
// Optional macro WORKERS_CPU_0_MUL_ZERO_SKIP_EN: a zero operand goes straight to DONE with a zero result.
module workers_cpu_0_cpu_mult_seq #(
  parameter int unsigned CELL_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        busy,
  output logic [31:0] cell_src1,
  output logic [31:0] cell_src2,
  output logic        cell_en,
  input  logic [31:0] cell_p1,
  input  logic [31:0] cell_p2,
  input  logic [31:0] cell_p3
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE1,
    S_ACC1,
    S_ISSUE2,
    S_ACC2,
    S_FIX,
    S_DONE
  } state_e;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXSS = 2'b11;
  localparam logic [1:0] CNT_LAST  = 2'(CELL_LAT - 1);

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] res_data_q, res_data_d;
  logic        res_valid_q, res_valid_d;
  logic [31:0] csrc1_q, csrc1_d;
  logic [31:0] csrc2_q, csrc2_d;
  logic [1:0]  cnt_q, cnt_d;

  logic        zero_skip;
  logic [63:0] pp_lo;
  logic [63:0] acc_hi;
  logic [31:0] corr_a;
  logic [31:0] corr_b;
  logic [31:0] hi_fix;

`ifdef WORKERS_CPU_0_MUL_ZERO_SKIP_EN
  assign zero_skip = (req_src1 == 32'h0) || (req_src2 == 32'h0);
`else
  assign zero_skip = 1'b0;
`endif

  // First pass: lo*lo plus both cross terms at weight 2^16, kept at full 64-bit width.
  assign pp_lo  = {32'h0, cell_p1} + {16'h0, cell_p2, 16'h0} + {16'h0, cell_p3, 16'h0};
  assign acc_hi = acc_q + {cell_p1, 32'h0};

  // Signed operand x = u - 2^32*x[31], so each signed operand subtracts the other from the high word.
  assign corr_a = (op_q[1] && a_q[31]) ? b_q : 32'h0;
  assign corr_b = ((op_q == OP_MULXSS) && b_q[31]) ? a_q : 32'h0;
  assign hi_fix = acc_q[63:32] - corr_a - corr_b;

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign cell_src1 = csrc1_q;
  assign cell_src2 = csrc2_q;
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    csrc1_d     = csrc1_q;
    csrc2_d     = csrc2_q;
    cnt_d       = cnt_q;
    req_ready   = 1'b0;
    cell_en     = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d = req_op;
          a_d  = req_src1;
          b_d  = req_src2;
          if (zero_skip) begin
            res_data_d  = 32'h0;
            res_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            csrc1_d = req_src1;
            csrc2_d = req_src2;
            cnt_d   = 2'd0;
            state_d = S_ISSUE1;
          end
        end
      end

      S_ISSUE1: begin
        cell_en = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_ACC1;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end

      S_ACC1: begin
        acc_d = pp_lo;
        if (op_q == OP_MUL) begin
          res_data_d  = pp_lo[31:0];
          res_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          csrc1_d = {16'h0, a_q[31:16]};
          csrc2_d = {16'h0, b_q[31:16]};
          cnt_d   = 2'd0;
          state_d = S_ISSUE2;
        end
      end

      S_ISSUE2: begin
        cell_en = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_ACC2;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end

      S_ACC2: begin
        acc_d   = acc_hi;
        state_d = S_FIX;
      end

      S_FIX: begin
        res_data_d  = hi_fix;
        res_valid_d = 1'b1;
        state_d     = S_DONE;
      end

      S_DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= 2'b00;
      a_q         <= 32'h0;
      b_q         <= 32'h0;
      acc_q       <= 64'h0;
      res_data_q  <= 32'h0;
      res_valid_q <= 1'b0;
      csrc1_q     <= 32'h0;
      csrc2_q     <= 32'h0;
      cnt_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      csrc1_q     <= csrc1_d;
      csrc2_q     <= csrc2_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_workers_cpu_0_cpu_mult_seq.sv
// Directed bench for workers_cpu_0_cpu_mult_seq with a behavioural model of the multiply cell.
module tb_workers_cpu_0_cpu_mult_seq;

  localparam int CELL_LAT = 1;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        busy;
  logic [31:0] cell_src1;
  logic [31:0] cell_src2;
  logic        cell_en;
  logic [31:0] cell_p1;
  logic [31:0] cell_p2;
  logic [31:0] cell_p3;

  int n_checks = 0;
  int n_fail   = 0;

  workers_cpu_0_cpu_mult_seq #(.CELL_LAT(CELL_LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_src1  (req_src1),
    .req_src2  (req_src2),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy),
    .cell_src1 (cell_src1),
    .cell_src2 (cell_src2),
    .cell_en   (cell_en),
    .cell_p1   (cell_p1),
    .cell_p2   (cell_p2),
    .cell_p3   (cell_p3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cell model: products captured on cell_en edges, then CELL_LAT-1 further pipeline stages.
  logic [31:0] m_p1 [CELL_LAT];
  logic [31:0] m_p2 [CELL_LAT];
  logic [31:0] m_p3 [CELL_LAT];

  always @(posedge clk) begin
    if (cell_en) begin
      m_p1[0] <= {16'h0, cell_src1[15:0]} * {16'h0, cell_src2[15:0]};
      m_p2[0] <= {16'h0, cell_src1[15:0]} * {16'h0, cell_src2[31:16]};
      m_p3[0] <= {16'h0, cell_src1[31:16]} * {16'h0, cell_src2[15:0]};
    end
    for (int i = 1; i < CELL_LAT; i++) begin
      m_p1[i] <= m_p1[i-1];
      m_p2[i] <= m_p2[i-1];
      m_p3[i] <= m_p3[i-1];
    end
  end

  assign cell_p1 = m_p1[CELL_LAT-1];
  assign cell_p2 = m_p2[CELL_LAT-1];
  assign cell_p3 = m_p3[CELL_LAT-1];

  // Drives one request from an idle DUT and waits (bounded) for res_valid; lat=-1 on timeout.
  task automatic issue_and_wait(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output int lat, output logic [31:0] data,
                                output logic en_seen, output logic rdy_seen);
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    req_valid = 1'b1;
    rdy_seen  = req_ready;
    en_seen   = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 40) begin
      en_seen = en_seen | cell_en;
      @(posedge clk); #1;
      lat++;
    end
    en_seen = en_seen | cell_en;
    data = res_data;
    if (!res_valid) lat = -1;
  endtask

  task automatic ack();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_res_valid got %b exp 0", res_valid); end
    n_checks++; if (res_data !== 32'h0) begin n_fail++; $display("FAIL rst_res_data got %h exp 0", res_data); end
    n_checks++; if (cell_en !== 1'b0) begin n_fail++; $display("FAIL rst_cell_en got %b exp 0", cell_en); end
    n_checks++; if (cell_src1 !== 32'h0 || cell_src2 !== 32'h0) begin
      n_fail++; $display("FAIL rst_cell_src got %h/%h exp 0/0", cell_src1, cell_src2); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready got %b exp 1", req_ready); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    int lat; logic [31:0] d; logic en; logic rdy;
    issue_and_wait(2'b00, 32'h00010003, 32'h00020005, lat, d, en, rdy);
    n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL mul_req_ready got %b exp 1", rdy); end
    n_checks++; if (d !== 32'h000B000F) begin n_fail++; $display("FAIL mul_data got %h exp 000b000f", d); end
    n_checks++; if (lat != 3) begin n_fail++; $display("FAIL mul_latency got %0d exp 3", lat); end
    ack();
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL mul_valid_drop got %b exp 0", res_valid); end
  endtask

  task automatic test_mulx_uu_ss();
    int lat; logic [31:0] d; logic en; logic rdy;
    issue_and_wait(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, d, en, rdy);
    n_checks++; if (d !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL mulxuu_data got %h exp fffffffe", d); end
    n_checks++; if (lat != 6) begin n_fail++; $display("FAIL mulxuu_latency got %0d exp 6", lat); end
    ack();
    issue_and_wait(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, d, en, rdy);
    n_checks++; if (d !== 32'h00000000) begin n_fail++; $display("FAIL mulxss_m1_data got %h exp 00000000", d); end
    n_checks++; if (lat != 6) begin n_fail++; $display("FAIL mulxss_m1_latency got %0d exp 6", lat); end
    ack();
  endtask

  task automatic test_mulx_su();
    int lat; logic [31:0] d; logic en; logic rdy;
    issue_and_wait(2'b10, 32'hFFFFFFFF, 32'h00000002, lat, d, en, rdy);
    n_checks++; if (d !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mulxsu_data got %h exp ffffffff", d); end
    ack();
    issue_and_wait(2'b11, 32'h80000000, 32'h00000002, lat, d, en, rdy);
    n_checks++; if (d !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mulxss_min_data got %h exp ffffffff", d); end
    ack();
    // Only src2 negative: MULXSU leaves it unsigned (2*0xFFFFFFFE hi=1), MULXSS gives 2*-2 hi=-1.
    issue_and_wait(2'b10, 32'h00000002, 32'hFFFFFFFE, lat, d, en, rdy);
    n_checks++; if (d !== 32'h00000001) begin n_fail++; $display("FAIL mulxsu_b_neg_data got %h exp 00000001", d); end
    ack();
    issue_and_wait(2'b11, 32'h00000002, 32'hFFFFFFFE, lat, d, en, rdy);
    n_checks++; if (d !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mulxss_b_neg_data got %h exp ffffffff", d); end
    ack();
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] d; logic en; logic rdy;
    issue_and_wait(2'b00, 32'h00000007, 32'h00000006, lat, d, en, rdy);
    n_checks++; if (d !== 32'd42) begin n_fail++; $display("FAIL bp_first_data got %h exp 0000002a", d); end
    req_op    = 2'b01;
    req_src1  = 32'hFFFFFFFF;
    req_src2  = 32'hFFFFFFFF;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (res_valid !== 1'b1 || res_data !== 32'd42) begin
        n_fail++; $display("FAIL bp_hold_%0d got valid=%b data=%h exp valid=1 data=0000002a", i, res_valid, res_data); end
      n_checks++; if (req_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_req_ready_%0d got %b exp 0", i, req_ready); end
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_in_handshake got %b exp 0", req_ready); end
    @(posedge clk); #1;
    res_ready = 1'b0;
    n_checks++; if (res_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_after_handshake got valid=%b ready=%b exp valid=0 ready=1", res_valid, req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_second_accept got busy=%b exp 1", busy); end
    lat = 1;
    while (!res_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++; if (lat != 6 || res_data !== 32'hFFFFFFFE) begin
      n_fail++; $display("FAIL bp_second_result got lat=%0d data=%h exp lat=6 data=fffffffe", lat, res_data); end
    ack();
  endtask

  task automatic test_reset_mid_op();
    int lat; logic [31:0] d; logic en; logic rdy;
    logic stray;
    req_op    = 2'b11;
    req_src1  = 32'hFFFFFFFF;
    req_src2  = 32'hFFFFFFFF;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    n_checks++; if (cell_en !== 1'b1 || cell_src1 !== 32'h0000FFFF) begin
      n_fail++; $display("FAIL rmid_issue2 got en=%b src1=%h exp en=1 src1=0000ffff", cell_en, cell_src1); end
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (res_valid !== 1'b0 || cell_en !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rmid_abort got valid=%b en=%b busy=%b exp 0/0/0", res_valid, cell_en, busy); end
    @(posedge clk); #1;
    reset = 1'b0;
    stray = 1'b0;
    repeat (8) begin
      stray = stray | res_valid | busy;
      @(posedge clk); #1;
    end
    n_checks++; if (stray !== 1'b0) begin n_fail++; $display("FAIL rmid_no_result got %b exp 0", stray); end
    issue_and_wait(2'b00, 32'h00010003, 32'h00020005, lat, d, en, rdy);
    n_checks++; if (d !== 32'h000B000F || lat != 3) begin
      n_fail++; $display("FAIL rmid_next_op got data=%h lat=%0d exp data=000b000f lat=3", d, lat); end
    ack();
  endtask

  task automatic test_zero_operand();
    int lat; logic [31:0] d; logic en; logic rdy;
    issue_and_wait(2'b11, 32'h00000000, 32'h12345678, lat, d, en, rdy);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL zero_data got %h exp 00000000", d); end
`ifdef WORKERS_CPU_0_MUL_ZERO_SKIP_EN
    n_checks++; if (lat != 1) begin n_fail++; $display("FAIL zero_latency got %0d exp 1", lat); end
    n_checks++; if (en !== 1'b0) begin n_fail++; $display("FAIL zero_cell_en got %b exp 0", en); end
`else
    n_checks++; if (lat != 6) begin n_fail++; $display("FAIL zero_latency got %0d exp 6", lat); end
    n_checks++; if (en !== 1'b1) begin n_fail++; $display("FAIL zero_cell_en got %b exp 1", en); end
`endif
    ack();
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_src1  = 32'h0;
    req_src2  = 32'h0;
    res_ready = 1'b0;
    test_reset();
    test_mul();
    test_mulx_uu_ss();
    test_mulx_su();
    test_back_to_back();
    test_reset_mid_op();
    test_zero_operand();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
